// File: rtl/stacker_game.sv
// ---------------------------------------------------------------------------
// stacker_game
//   Stacker game engine for an 8x8 LED matrix. Owns the frame, slides the
//   active block row left/right on a fixed tick, and locks it on a button
//   press. A lock trims the block to its overlap with the row below and
//   climbs one level. Zero overlap ends the game (OVER). A successful lock
//   on the top row wins (WIN). Any press in OVER/WIN restarts the game.
//
//   Optional build macro: SPEEDUP_EN
//     When defined, the tick period shrinks by SPEED_STEP per level, and is
//     never shorter than 2 cycles.
//
// Ports
//   clk        in   1  system clock, rising edge
//   reset      in   1  asynchronous reset, active low
//   btn        in   1  raw push-button, active high, asynchronous
//   row0..row7 out  8  frame rows, 1 = LED on, row0 = bottom, bit0 = right
//   level      out  3  index of the row currently moving
//   game_over  out  1  high while in OVER
//   game_win   out  1  high while in WIN
// ---------------------------------------------------------------------------
// state  | meaning
// S_PLAY | active row bounces, press locks it
// S_OVER | frozen after a zero-overlap lock, press restarts
// S_WIN  | frozen after locking the top row, press restarts
// ---------------------------------------------------------------------------
module stacker_game #(
    parameter int TICK_DIV    = 5_000_000,
    parameter int START_WIDTH = 3,
    parameter int SPEED_STEP  = 500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn,
    output logic [7:0] row0,
    output logic [7:0] row1,
    output logic [7:0] row2,
    output logic [7:0] row3,
    output logic [7:0] row4,
    output logic [7:0] row5,
    output logic [7:0] row6,
    output logic [7:0] row7,
    output logic [2:0] level,
    output logic       game_over,
    output logic       game_win
);

    localparam int         CNT_W     = $clog2(TICK_DIV);
    localparam logic [7:0] START_ROW = 8'((16'd1 << START_WIDTH) - 16'd1);

    typedef enum logic [1:0] {
        S_PLAY = 2'd0,
        S_OVER = 2'd1,
        S_WIN  = 2'd2
    } state_t;

    state_t           state_q;
    logic [7:0]       rows_q [8];
    logic [2:0]       level_q;
    logic             dir_left_q;
    logic [CNT_W-1:0] tick_q;
    logic             btn_s1_q;
    logic             btn_s2_q;
    logic             btn_dly_q;
    logic             game_over_q;
    logic             game_win_q;

    logic             press;
    logic             tick_wrap;
    logic [7:0]       active;
    logic [7:0]       below;
    logic [7:0]       lock_row;
    logic [7:0]       step_row_d;
    logic             step_dir_left_d;

    // Rising edge of the synchronized button; a held button gives one pulse.
    assign press = btn_s2_q & ~btn_dly_q;

    always_comb begin
        active          = rows_q[level_q];
        // The bottom row has nothing beneath it, so it locks untrimmed.
        below           = (level_q == 3'd0) ? 8'hFF : rows_q[level_q - 3'd1];
        lock_row        = active & below;
        step_row_d      = active;
        step_dir_left_d = dir_left_q;
        if (active == 8'hFF) begin
            // Full-width block cannot move; only the direction flips.
            step_dir_left_d = ~dir_left_q;
        end else if (dir_left_q) begin
            if (active[7]) begin
                step_dir_left_d = 1'b0;
                step_row_d      = active >> 1;
            end else begin
                step_row_d      = active << 1;
            end
        end else begin
            if (active[0]) begin
                step_dir_left_d = 1'b1;
                step_row_d      = active << 1;
            end else begin
                step_row_d      = active >> 1;
            end
        end
    end

`ifdef SPEEDUP_EN
    logic [31:0] speed_dec;
    logic [31:0] period;

    always_comb begin
        speed_dec = 32'(level_q) * 32'(SPEED_STEP);
        if (speed_dec + 32'd2 > 32'(TICK_DIV)) begin
            period = 32'd2;
        end else begin
            period = 32'(TICK_DIV) - speed_dec;
        end
    end

    // >= rather than == so a shorter period never lets the count run past it.
    assign tick_wrap = (32'(tick_q) >= period - 32'd1);
`else
    logic unused_speed_step;
    assign unused_speed_step = ^SPEED_STEP;
    assign tick_wrap         = (tick_q == CNT_W'(TICK_DIV - 1));
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_PLAY;
            level_q     <= 3'd0;
            dir_left_q  <= 1'b1;
            tick_q      <= '0;
            btn_s1_q    <= 1'b0;
            btn_s2_q    <= 1'b0;
            btn_dly_q   <= 1'b0;
            game_over_q <= 1'b0;
            game_win_q  <= 1'b0;
            rows_q[0]   <= START_ROW;
            for (int i = 1; i < 8; i++) begin
                rows_q[i] <= 8'h00;
            end
        end else begin
            btn_s1_q  <= btn;
            btn_s2_q  <= btn_s1_q;
            btn_dly_q <= btn_s2_q;
            case (state_q)
                S_PLAY: begin
                    if (press) begin
                        // A press wins over a coincident step: lock the pre-step row.
                        tick_q           <= '0;
                        rows_q[level_q]  <= lock_row;
                        if (lock_row == 8'h00) begin
                            state_q     <= S_OVER;
                            game_over_q <= 1'b1;
                        end else if (level_q == 3'd7) begin
                            state_q    <= S_WIN;
                            game_win_q <= 1'b1;
                        end else begin
                            level_q                 <= level_q + 3'd1;
                            rows_q[level_q + 3'd1]  <= lock_row;
                        end
                    end else if (tick_wrap) begin
                        tick_q          <= '0;
                        rows_q[level_q] <= step_row_d;
                        dir_left_q      <= step_dir_left_d;
                    end else begin
                        tick_q <= tick_q + CNT_W'(1);
                    end
                end
                default: begin
                    // OVER, WIN (and any stray encoding): frame frozen until a press.
                    // Synchronizer flops keep running so a held button is not re-seen.
                    tick_q <= '0;
                    if (press) begin
                        state_q     <= S_PLAY;
                        level_q     <= 3'd0;
                        dir_left_q  <= 1'b1;
                        game_over_q <= 1'b0;
                        game_win_q  <= 1'b0;
                        rows_q[0]   <= START_ROW;
                        for (int i = 1; i < 8; i++) begin
                            rows_q[i] <= 8'h00;
                        end
                    end
                end
            endcase
        end
    end

    assign row0      = rows_q[0];
    assign row1      = rows_q[1];
    assign row2      = rows_q[2];
    assign row3      = rows_q[3];
    assign row4      = rows_q[4];
    assign row5      = rows_q[5];
    assign row6      = rows_q[6];
    assign row7      = rows_q[7];
    assign level     = level_q;
    assign game_over = game_over_q;
    assign game_win  = game_win_q;

endmodule
